axi4lite_slave: RTL and testbench

- AXI4-Lite responder that converts AXI4-Lite transactions into the simple single-beat memory interface (addr/wdata/wstrb/req/we, ready/valid) used by on-chip RAM and peripherals.
- It is the target-side counterpart of the core's AXI4-Lite master and sits between the interconnect and a memory or register block.
- It serializes reads and writes, one outstanding transaction in total, with round-robin arbitration.
- Addresses outside its window are answered with DECERR and never reach the memory side.

---
 rtl/axi4lite_pkg.sv | 30 +++
 rtl/rv32i_pkg.sv | 7 +
 rtl/axi4lite_hold_reg.sv | 39 +++
 rtl/axi4lite_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi4lite_slave.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: AXI4-Lite widths, response codes and slave FSM states.
// Shared by the AXI4-Lite master and slave adapters.
package axi4lite_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_B_RESP,
      S_R_RESP
   } axi_slave_state_e;

   // Wrap-around offset compare, so windows near 2^32 decode correctly.
   function automatic logic in_window(
      input logic [AXI_ADDR_WIDTH-1:0] addr,
      input logic [AXI_ADDR_WIDTH-1:0] base,
      input logic [AXI_ADDR_WIDTH-1:0] size
   );
      return (addr - base) < size;
   endfunction

endpackage

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: core-wide architectural constants.
// Shared by the core and its bus adapters.
package rv32i_pkg;

   localparam int XLEN = 32;

endpackage

// File: rtl/axi4lite_hold_reg.sv
// axi4lite_hold_reg: single-entry valid/ready holding register.
// Ready comes from the registered full flag only, never from valid.
module axi4lite_hold_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   input  logic         i_clr,
   output logic         o_ready,
   output logic         o_full,
   output logic [W-1:0] o_data
);

   logic         r_full;
   logic [W-1:0] r_data;
   logic         w_ready;

   assign w_ready = i_en & ~r_full;
   assign o_ready = w_ready;
   assign o_full  = r_full;
   assign o_data  = r_data;

   // Capture payload on handshake; release when the response completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_clr) begin
         r_full <= 1'b0;
      end else if (i_valid && w_ready) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end

endmodule

// File: rtl/axi4lite_slave.sv
// axi4lite_slave: AXI4-Lite responder onto a single-beat memory port.
// One transaction in flight; reads and writes alternate when both wait.
module axi4lite_slave
   import axi4lite_pkg::*;
   import rv32i_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [XLEN-1:0]           mem_addr,
   output logic [XLEN-1:0]           mem_wdata,
   output logic [3:0]                mem_wstrb,
   output logic                      mem_req,
   output logic                      mem_we,
   input  logic                      mem_ready,
   input  logic                      mem_valid,
   input  logic [XLEN-1:0]           mem_rdata
);

   localparam int WW = AXI_DATA_WIDTH + AXI_STRB_WIDTH;

   axi_slave_state_e r_state;

   logic                      r_up;
   logic                      r_rr_last_write;
   logic [XLEN-1:0]           r_mem_addr;
   logic [XLEN-1:0]           r_mem_wdata;
   logic [3:0]                r_mem_wstrb;
   logic                      r_mem_req;
   logic                      r_mem_we;
   logic [1:0]                r_bresp;
   logic                      r_bvalid;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                r_rresp;
   logic                      r_rvalid;

   logic                      w_aw_full;
   logic                      w_w_full;
   logic                      w_ar_full;
   logic [AXI_ADDR_WIDTH-1:0] w_aw_addr;
   logic [AXI_ADDR_WIDTH-1:0] w_ar_addr;
   logic [WW-1:0]             w_w_data;
   logic                      w_b_hs;
   logic                      w_r_hs;
   logic                      w_wr_rdy;
   logic                      w_rd_rdy;
   logic                      w_pick_wr;
   logic                      w_done;

   assign w_b_hs    = r_bvalid & s_axi_bready;
   assign w_r_hs    = r_rvalid & s_axi_rready;
   assign w_wr_rdy  = w_aw_full & w_w_full;
   assign w_rd_rdy  = w_ar_full;
   assign w_pick_wr = w_wr_rdy & (~w_rd_rdy | ~r_rr_last_write);
   assign w_done    = ((r_state == S_MEM_REQ) & mem_ready & mem_valid) |
                      ((r_state == S_MEM_WAIT) & mem_valid);

   axi4lite_hold_reg #(.W(AXI_ADDR_WIDTH)) u_aw (
      .clk(clk), .rst(rst), .i_en(r_up),
      .i_valid(s_axi_awvalid), .i_data(s_axi_awaddr), .i_clr(w_b_hs),
      .o_ready(s_axi_awready), .o_full(w_aw_full), .o_data(w_aw_addr)
   );

   axi4lite_hold_reg #(.W(WW)) u_w (
      .clk(clk), .rst(rst), .i_en(r_up),
      .i_valid(s_axi_wvalid), .i_data({s_axi_wstrb, s_axi_wdata}),
      .i_clr(w_b_hs),
      .o_ready(s_axi_wready), .o_full(w_w_full), .o_data(w_w_data)
   );

   axi4lite_hold_reg #(.W(AXI_ADDR_WIDTH)) u_ar (
      .clk(clk), .rst(rst), .i_en(r_up),
      .i_valid(s_axi_arvalid), .i_data(s_axi_araddr), .i_clr(w_r_hs),
      .o_ready(s_axi_arready), .o_full(w_ar_full), .o_data(w_ar_addr)
   );

   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_wstrb    = r_mem_wstrb;
   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign s_axi_bresp  = r_bresp;
   assign s_axi_bvalid = r_bvalid;
   assign s_axi_rdata  = r_rdata;
   assign s_axi_rresp  = r_rresp;
   assign s_axi_rvalid = r_rvalid;

   // Dispatch, memory sequencing and response generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_up            <= 1'b0;
         r_rr_last_write <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wdata     <= '0;
         r_mem_wstrb     <= '0;
         r_mem_req       <= 1'b0;
         r_mem_we        <= 1'b0;
         r_bresp         <= AXI_RESP_OKAY;
         r_bvalid        <= 1'b0;
         r_rdata         <= '0;
         r_rresp         <= AXI_RESP_OKAY;
         r_rvalid        <= 1'b0;
      end else begin
         r_up <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (w_pick_wr) begin
                  r_rr_last_write <= 1'b1;
                  if (in_window(w_aw_addr, BASE_ADDR, ADDR_SIZE)) begin
                     r_mem_addr  <= XLEN'(w_aw_addr - BASE_ADDR);
                     r_mem_wdata <= w_w_data[AXI_DATA_WIDTH-1:0];
                     r_mem_wstrb <= w_w_data[WW-1:AXI_DATA_WIDTH];
                     r_mem_we    <= 1'b1;
                     r_mem_req   <= 1'b1;
                     r_state     <= S_MEM_REQ;
                  end else begin
                     r_bresp  <= AXI_RESP_DECERR;
                     r_bvalid <= 1'b1;
                     r_state  <= S_B_RESP;
                  end
               end else if (w_rd_rdy) begin
                  r_rr_last_write <= 1'b0;
                  if (in_window(w_ar_addr, BASE_ADDR, ADDR_SIZE)) begin
                     r_mem_addr  <= XLEN'(w_ar_addr - BASE_ADDR);
                     r_mem_wdata <= '0;
                     r_mem_wstrb <= 4'b0000;
                     r_mem_we    <= 1'b0;
                     r_mem_req   <= 1'b1;
                     r_state     <= S_MEM_REQ;
                  end else begin
                     r_rresp  <= AXI_RESP_DECERR;
                     r_rdata  <= '0;
                     r_rvalid <= 1'b1;
                     r_state  <= S_R_RESP;
                  end
               end
            end
            S_MEM_REQ: begin
               if (mem_ready && !mem_valid) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_MEM_WAIT;
               end
            end
            S_MEM_WAIT: begin
            end
            S_B_RESP: begin
               if (s_axi_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_R_RESP: begin
               if (s_axi_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_done) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
               r_bresp  <= AXI_RESP_OKAY;
               r_bvalid <= 1'b1;
               r_state  <= S_B_RESP;
            end else begin
               r_rresp  <= AXI_RESP_OKAY;
               r_rdata  <= mem_rdata;
               r_rvalid <= 1'b1;
               r_state  <= S_R_RESP;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_slave.sv
// tb_axi4lite_slave: directed self-checking bench for axi4lite_slave.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_axi4lite_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;
   int req_cnt = 0;
   int req_base;

   axi4lite_slave dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
      .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_req && mem_ready) req_cnt <= req_cnt + 1;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, {29'd0, awready, wready, arready}, 32'd0);
      chk({tag, "_valid"}, {30'd0, bvalid, rvalid}, 32'd0);
      chk({tag, "_resp"}, {28'd0, bresp, rresp}, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
      chk({tag, "_mreq"}, {30'd0, mem_req, mem_we}, 32'd0);
      chk({tag, "_maddr"}, mem_addr, 32'd0);
      chk({tag, "_mwdata"}, mem_wdata, 32'd0);
      chk({tag, "_mwstrb"}, {28'd0, mem_wstrb}, 32'd0);
   endtask

   task automatic send_aw(input logic [31:0] a);
      int n = 0;
      awaddr = a; awvalid = 1'b1;
      while (!awready && n < 50) begin tick(); n++; end
      chk("aw_timeout", {31'd0, awready}, 32'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      while (!wready && n < 50) begin tick(); n++; end
      chk("w_timeout", {31'd0, wready}, 32'd1);
      tick();
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a);
      int n = 0;
      araddr = a; arvalid = 1'b1;
      while (!arready && n < 50) begin tick(); n++; end
      chk("ar_timeout", {31'd0, arready}, 32'd1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!mem_req && n < 50) begin tick(); n++; end
      chk("req_timeout", {31'd0, mem_req}, 32'd1);
   endtask

   task automatic serve(input logic fast, input logic [31:0] rd);
      if (!fast) tick();
      mem_valid = 1'b1; mem_rdata = rd;
      tick();
      mem_valid = 1'b0;
   endtask

   task automatic bcheck(input string tag, input logic [1:0] er);
      int n = 0;
      while (!bvalid && n < 50) begin tick(); n++; end
      chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
      chk({tag, "_bresp"}, {30'd0, bresp}, {30'd0, er});
      chk({tag, "_awwready"}, {30'd0, awready, wready}, 32'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk({tag, "_bdone"}, {31'd0, bvalid}, 32'd0);
   endtask

   task automatic rcheck(input string tag, input logic [1:0] er,
                         input logic [31:0] ed);
      int n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
      chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, er});
      chk({tag, "_rdata"}, rdata, ed);
      chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk({tag, "_rdone"}, {31'd0, rvalid}, 32'd0);
   endtask

   initial begin
      // Reset
      tick(); tick();
      chk_idle_outputs("rst");
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

      // Aligned write, AW and W together, memory completes one cycle late
      req_base = req_cnt;
      awaddr = 32'h100; awvalid = 1'b1;
      wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t1_ready_low", {30'd0, awready, wready}, 32'd0);
      wait_req();
      chk("t1_maddr", mem_addr, 32'h100);
      chk("t1_mwe", {31'd0, mem_we}, 32'd1);
      chk("t1_mwstrb", {28'd0, mem_wstrb}, 32'hF);
      chk("t1_mwdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("t1_wait_noreq", {31'd0, mem_req}, 32'd0);
      chk("t1_wait_nob", {31'd0, bvalid}, 32'd0);
      serve(1'b1, 32'h0);
      bcheck("t1", 2'b00);
      chk("t1_reqs", req_cnt - req_base, 32'd1);

      // W leads AW by three cycles; minimum-latency completion
      req_base = req_cnt;
      send_w(32'h1234_5678, 4'hF);
      chk("t2_wready_low", {31'd0, wready}, 32'd0);
      tick(); tick();
      chk("t2_no_early_req", {31'd0, mem_req}, 32'd0);
      send_aw(32'h8);
      chk("t2_idle_noreq", {31'd0, mem_req}, 32'd0);
      tick();
      chk("t2_req", {31'd0, mem_req}, 32'd1);
      chk("t2_maddr", mem_addr, 32'h8);
      chk("t2_mwdata", mem_wdata, 32'h1234_5678);
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
      chk("t2_lat_bvalid", {31'd0, bvalid}, 32'd1);
      bcheck("t2", 2'b00);
      chk("t2_reqs", req_cnt - req_base, 32'd1);

      // Out-of-window read answered with DECERR
      req_base = req_cnt;
      send_ar(32'h0001_0000);
      rcheck("t3", 2'b11, 32'h0);
      chk("t3_noreq", req_cnt - req_base, 32'd0);

      // Round robin with last served = read: write goes first
      awaddr = 32'h20; awvalid = 1'b1;
      wdata = 32'hA5A5_0001; wstrb = 4'h3; wvalid = 1'b1;
      araddr = 32'h24; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      wait_req();
      chk("t4a_first_we", {31'd0, mem_we}, 32'd1);
      chk("t4a_first_addr", mem_addr, 32'h20);
      chk("t4a_first_strb", {28'd0, mem_wstrb}, 32'h3);
      serve(1'b1, 32'h0);
      bcheck("t4a_w", 2'b00);
      wait_req();
      chk("t4a_second_we", {31'd0, mem_we}, 32'd0);
      chk("t4a_second_addr", mem_addr, 32'h24);
      chk("t4a_second_strb", {28'd0, mem_wstrb}, 32'h0);
      serve(1'b1, 32'h0000_55AA);
      rcheck("t4a_r", 2'b00, 32'h0000_55AA);

      // Single write so the last served is a write
      send_aw(32'h30);
      send_w(32'h0000_0030, 4'hF);
      wait_req();
      serve(1'b1, 32'h0);
      bcheck("t4b_pre", 2'b00);

      // Round robin with last served = write: read goes first
      awaddr = 32'h34; awvalid = 1'b1;
      wdata = 32'h0000_0034; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 32'h38; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      wait_req();
      chk("t4b_first_we", {31'd0, mem_we}, 32'd0);
      chk("t4b_first_addr", mem_addr, 32'h38);
      serve(1'b0, 32'h1111_2222);
      rcheck("t4b_r", 2'b00, 32'h1111_2222);
      wait_req();
      chk("t4b_second_we", {31'd0, mem_we}, 32'd1);
      chk("t4b_second_addr", mem_addr, 32'h34);
      serve(1'b1, 32'h0);
      bcheck("t4b_w", 2'b00);

      // Memory stall in MEM_REQ, then R backpressure for five cycles
      send_ar(32'h40);
      mem_ready = 1'b0;
      wait_req();
      tick();
      chk("t5_stall_req", {31'd0, mem_req}, 32'd1);
      chk("t5_stall_addr", mem_addr, 32'h40);
      mem_ready = 1'b1;
      serve(1'b0, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_rvalid", {31'd0, rvalid}, 32'd1);
         chk("t5_hold_rdata", rdata, 32'hCAFE_F00D);
         chk("t5_hold_rresp", {30'd0, rresp}, 32'd0);
         chk("t5_hold_arready", {31'd0, arready}, 32'd0);
         tick();
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("t5_rdone", {31'd0, rvalid}, 32'd0);
      chk("t5_arready_back", {31'd0, arready}, 32'd1);

      // Reset while waiting on memory; stale mem_valid must be ignored
      send_aw(32'h50);
      send_w(32'h0000_0050, 4'hF);
      wait_req();
      tick();
      chk("t6_in_wait", {31'd0, mem_req}, 32'd0);
      rst = 1'b1;
      #1;
      chk_idle_outputs("t6_rst");
      tick();
      mem_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("t6_stale_mreq", {31'd0, mem_req}, 32'd0);
      chk("t6_stale_resp", {30'd0, bvalid, rvalid}, 32'd0);
      mem_valid = 1'b0;
      req_base = req_cnt;
      send_aw(32'h60);
      send_w(32'h6060_6060, 4'hC);
      wait_req();
      chk("t6_fresh_addr", mem_addr, 32'h60);
      chk("t6_fresh_strb", {28'd0, mem_wstrb}, 32'hC);
      serve(1'b1, 32'h0);
      bcheck("t6", 2'b00);
      chk("t6_reqs", req_cnt - req_base, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
